psram_axi_bridge: RTL and testbench

AXI4 slave front end for the PSRAM controller: accepts AXI4 read and write bursts and breaks them into single-word transfer requests on the controller core's `xfer_*` / `bus_*` port. It sits directly upstream of `psram_core`, between the system AXI4 interconnect and the core, on the AXI clock domain. One burst is in flight at a time, and read/write arbitration is round-robin.

---
 rtl/psram_axi_bridge_pkg.sv | 30 +++
 rtl/psram_axi_bridge_if.sv | 58 +++++
 rtl/psram_axi_bridge_addr_gen.sv | 35 +++
 rtl/psram_axi_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_psram_axi_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_axi_bridge_pkg.sv
// Shared constants and types for the PSRAM AXI4 front end: burst and
// response encodings, the bridge FSM state type and a range-check helper.
package psram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_XFER,
    ST_WR_RESP,
    ST_RD_XFER,
    ST_RD_DATA
  } psram_axi_state_e;

  // True when a byte address falls outside the mapped PSRAM window.
  function automatic logic addr_out_of_range(input logic [63:0] addr,
                                             input logic [63:0] limit);
    return (addr >= limit);
  endfunction

endpackage

// File: rtl/psram_axi_bridge_if.sv
// AXI4 five-channel bundle between the interconnect (master) and the
// PSRAM bridge (slave).
interface psram_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/psram_axi_bridge_addr_gen.sv
// Combinational AXI4 next-beat address calculator with out-of-range flag.
module psram_axi_addr_gen
  import psram_axi_bridge_pkg::*;
#(
  parameter int              ADDR_WIDTH    = 32,
  parameter longint unsigned USR_ADDR_SIZE = 64*1024*1024
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  oor_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // Step is a power of two, so the wrap span (len+1)*step is a shift and
  // the legal WRAP lengths make it a power of two as well.
  always_comb begin
    step        = ADDR_WIDTH'(1) << size_i;
    incr_addr   = addr_i + step;
    wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    next_addr_o = incr_addr;
    case (axi_burst_e'(burst_i))
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = incr_addr;
    endcase
    oor_o = addr_out_of_range(64'(addr_i), 64'(USR_ADDR_SIZE));
  end

endmodule

// File: rtl/psram_axi_bridge.sv
// AXI4 slave front end for psram_core: one burst at a time, split into
// single-word xfer requests, round-robin between reads and writes.
module psram_axi_bridge
  import psram_axi_bridge_pkg::*;
#(
  parameter int              ADDR_WIDTH    = 32,
  parameter int              DATA_WIDTH    = 32,
  parameter int              ID_WIDTH      = 4,
  parameter longint unsigned USR_ADDR_SIZE = 64*1024*1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  psram_axi_bridge_if.slave       axi,
  output logic                    xfer_valid_o,
  output logic                    xfer_rdwr_o,
  input  logic                    xfer_ready_i,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wr_data_o,
  output logic [DATA_WIDTH/8-1:0] bus_wr_mask_o,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data_i
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(DATA_WIDTH/8 - 1);

  psram_axi_state_e        state_q;
  logic                    last_rd_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              beat_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    xfer_valid_q;
  logic                    xfer_rdwr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic                    rlast_q;
  logic                    rvalid_q;
  logic [1:0]              bresp_q;
  logic                    bvalid_q;

  logic [ADDR_WIDTH-1:0]   next_addr_d;
  logic                    cur_oor;
  logic                    next_oor;
  logic                    ar_oor;
  logic                    grant_wr;
  logic                    grant_rd;
  logic                    is_last;

  psram_axi_addr_gen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .USR_ADDR_SIZE (USR_ADDR_SIZE)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr_d),
    .oor_o       (cur_oor)
  );

  // Arbitration: on a tie, grant whichever type was not served last.
  always_comb begin
    grant_wr = (state_q == ST_IDLE) && axi.awvalid && (!axi.arvalid || last_rd_q);
    grant_rd = (state_q == ST_IDLE) && axi.arvalid && !grant_wr;
    is_last  = (beat_q == len_q);
    ar_oor   = addr_out_of_range(64'(axi.araddr), 64'(USR_ADDR_SIZE));
    next_oor = addr_out_of_range(64'(next_addr_d), 64'(USR_ADDR_SIZE));
  end

  assign axi.awready   = grant_wr;
  assign axi.arready   = grant_rd;
  assign axi.wready    = (state_q == ST_WR_DATA);
  assign axi.bvalid    = bvalid_q;
  assign axi.bresp     = bresp_q;
  assign axi.bid       = id_q;
  assign axi.rvalid    = rvalid_q;
  assign axi.rdata     = rdata_q;
  assign axi.rresp     = rresp_q;
  assign axi.rlast     = rlast_q;
  assign axi.rid       = id_q;
  assign xfer_valid_o  = xfer_valid_q;
  assign xfer_rdwr_o   = xfer_rdwr_q;
  assign bus_addr_o    = addr_q & WORD_MASK;
  assign bus_wr_data_o = wdata_q;
  assign bus_wr_mask_o = wstrb_q;

  // Burst sequencer with registered AXI response and core request outputs.
  // Out-of-range beats spend one cycle in the XFER state with no request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_rd_q    <= 1'b1;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      xfer_valid_q <= 1'b0;
      xfer_rdwr_q  <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rlast_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      bvalid_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_wr) begin
            id_q      <= axi.awid;
            addr_q    <= axi.awaddr;
            len_q     <= axi.awlen;
            size_q    <= axi.awsize;
            burst_q   <= axi.awburst;
            beat_q    <= '0;
            err_q     <= (axi.awburst == BURST_RSVD);
            last_rd_q <= 1'b0;
            state_q   <= ST_WR_DATA;
          end else if (grant_rd) begin
            id_q         <= axi.arid;
            addr_q       <= axi.araddr;
            len_q        <= axi.arlen;
            size_q       <= axi.arsize;
            burst_q      <= axi.arburst;
            beat_q       <= '0;
            err_q        <= (axi.arburst == BURST_RSVD);
            last_rd_q    <= 1'b1;
            xfer_valid_q <= !ar_oor;
            xfer_rdwr_q  <= 1'b1;
            state_q      <= ST_RD_XFER;
          end
        end

        ST_WR_DATA: begin
          if (axi.wvalid) begin
            wdata_q      <= axi.wdata;
            wstrb_q      <= axi.wstrb;
            if (axi.wlast != is_last) err_q <= 1'b1;
            xfer_valid_q <= !cur_oor;
            state_q      <= ST_WR_XFER;
          end
        end

        ST_WR_XFER: begin
          if (cur_oor || xfer_ready_i) begin
            xfer_valid_q <= 1'b0;
            if (cur_oor) err_q <= 1'b1;
            if (is_last) begin
              bresp_q  <= (err_q || cur_oor) ? RESP_SLVERR : RESP_OKAY;
              bvalid_q <= 1'b1;
              state_q  <= ST_WR_RESP;
            end else begin
              addr_q  <= next_addr_d;
              beat_q  <= beat_q + 8'd1;
              state_q <= ST_WR_DATA;
            end
          end
        end

        ST_WR_RESP: begin
          if (axi.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        // Read responses are graded per beat; err_q here only carries the
        // reserved-burst condition latched at grant.
        ST_RD_XFER: begin
          if (cur_oor || xfer_ready_i) begin
            xfer_valid_q <= 1'b0;
            xfer_rdwr_q  <= 1'b0;
            rdata_q      <= cur_oor ? '0 : bus_rd_data_i;
            rresp_q      <= (cur_oor || err_q) ? RESP_SLVERR : RESP_OKAY;
            rlast_q      <= is_last;
            rvalid_q     <= 1'b1;
            state_q      <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (axi.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (is_last) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q       <= next_addr_d;
              beat_q       <= beat_q + 8'd1;
              xfer_valid_q <= !next_oor;
              xfer_rdwr_q  <= 1'b1;
              state_q      <= ST_RD_XFER;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_axi_bridge.sv
// Directed plus randomized bench for psram_axi_bridge with a simple PSRAM
// core responder and a burst-level reference model.
module tb_psram_axi_bridge;

  localparam int              AW  = 32;
  localparam int              DW  = 32;
  localparam int              IW  = 4;
  localparam longint unsigned USR = 64*1024*1024;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        xfer_valid_o, xfer_rdwr_o, xfer_ready_i;
  logic [31:0] bus_addr_o, bus_wr_data_o, bus_rd_data_i;
  logic [3:0]  bus_wr_mask_o;

  always #5 clk = ~clk;

  psram_axi_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  psram_axi_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ID_WIDTH      (IW),
    .USR_ADDR_SIZE (USR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .axi           (axi),
    .xfer_valid_o  (xfer_valid_o),
    .xfer_rdwr_o   (xfer_rdwr_o),
    .xfer_ready_i  (xfer_ready_i),
    .bus_addr_o    (bus_addr_o),
    .bus_wr_data_o (bus_wr_data_o),
    .bus_wr_mask_o (bus_wr_mask_o),
    .bus_rd_data_i (bus_rd_data_i)
  );

  typedef struct packed {
    logic        rdwr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  req_t        obs_q[$];
  req_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          core_hold   = 1'b0;
  int unsigned core_wait   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no handshake expected handshake within budget", tag);
  endtask

  // Contents of the modelled PSRAM word at a word-aligned address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Byte address of beat i, straight from the AXI4 burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int unsigned i);
    longint unsigned s, step, bnd, base;
    s    = start;
    step = longint'(1) << size;
    case (burst)
      2'b00:   return start;
      2'b10: begin
        bnd  = (longint'(len) + 1) * step;
        base = s - (s % bnd);
        return 32'(base + ((s - base) + i * step) % bnd);
      end
      default: return 32'(s + i * step);
    endcase
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return longint'(a) >= USR;
  endfunction

  // Core responder: acknowledges each request after 0..3 idle cycles.
  initial begin
    req_t r;
    xfer_ready_i  = 1'b0;
    bus_rd_data_i = '0;
    forever begin
      @(negedge clk);
      xfer_ready_i  = 1'b0;
      bus_rd_data_i = $urandom;
      if (xfer_valid_o && !core_hold && !rst_i) begin
        if (core_wait == 0) begin
          r.rdwr = xfer_rdwr_o;
          r.addr = bus_addr_o;
          if (xfer_rdwr_o) begin
            r.data        = mem_word(bus_addr_o);
            r.mask        = '0;
            bus_rd_data_i = r.data;
          end else begin
            r.data = bus_wr_data_o;
            r.mask = bus_wr_mask_o;
          end
          obs_q.push_back(r);
          xfer_ready_i = 1'b1;
          core_wait    = $urandom_range(0, 3);
        end else begin
          core_wait--;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic compare_core(input string tag);
    int n;
    check({tag, "_req_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_req"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    @(negedge clk);
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    for (int c = 0; ; c++) begin
      #1;
      if (axi.awready) break;
      if (c > 200) begin timeout("aw_hs"); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    @(negedge clk);
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arvalid = 1'b1;
    for (int c = 0; ; c++) begin
      #1;
      if (axi.arready) break;
      if (c > 200) begin timeout("ar_hs"); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
  endtask

  // Write burst; s0 != 0 fixes data/strobe for every beat. bad_beat flips
  // wlast on that beat. Returns just after the B handshake edge.
  task automatic write_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                           input logic [31:0] d0, input logic [3:0] s0, input bit do_aw);
    bit          err;
    logic [31:0] a, d;
    logic [3:0]  s;
    if (do_aw) aw_hs(id, addr, len, size, burst);
    err = (burst == 2'b11);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      d = (s0 != 0) ? d0 : $urandom;
      s = (s0 != 0) ? s0 : 4'($urandom_range(1, 15));
      if (i == bad_beat) err = 1'b1;
      if (oor(a)) err = 1'b1;
      else exp_q.push_back({1'b0, a & 32'hFFFF_FFFC, d, s});
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      axi.wdata = d; axi.wstrb = s; axi.wlast = (i == int'(len)) ^ (i == bad_beat);
      axi.wvalid = 1'b1;
      for (int c = 0; ; c++) begin
        #1;
        if (axi.wready) break;
        if (c > 200) begin timeout("w_hs"); break; end
        @(negedge clk);
      end
      @(posedge clk); #1;
      axi.wvalid = 1'b0;
      check("w_xfer_latency", xfer_valid_o, !oor(a));
    end
    for (int c = 0; ; c++) begin
      @(negedge clk);
      axi.bready = (c > 3) ? 1'b1 : 1'($urandom);
      #1;
      if (axi.bvalid && axi.bready) break;
      if (c > 200) begin timeout("b_hs"); break; end
    end
    check("b_id", axi.bid, id);
    check("b_resp", axi.bresp, err ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    axi.bready = 1'b0;
    compare_core("wr");
  endtask

  // Read burst; called (or continued) just after the AR handshake edge.
  task automatic read_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit do_ar);
    logic [31:0] a, ed;
    bit          bad;
    if (do_ar) ar_hs(id, addr, len, size, burst);
    check("r_first_xfer", xfer_valid_o, !oor(beat_addr(addr, size, len, burst, 0)));
    for (int i = 0; i <= int'(len); i++) begin
      a   = beat_addr(addr, size, len, burst, i);
      bad = oor(a);
      ed  = bad ? 32'h0 : mem_word(a & 32'hFFFF_FFFC);
      if (!bad) exp_q.push_back({1'b1, a & 32'hFFFF_FFFC, ed, 4'h0});
      for (int c = 0; ; c++) begin
        @(negedge clk);
        axi.rready = (c > 3) ? 1'b1 : 1'($urandom);
        #1;
        if (axi.rvalid && axi.rready) break;
        if (c > 200) begin timeout("r_hs"); break; end
      end
      check("r_data", axi.rdata, ed);
      check("r_id_resp_last", {axi.rid, axi.rresp, axi.rlast},
            {id, (bad || burst == 2'b11) ? 2'b10 : 2'b00, i == int'(len)});
      @(posedge clk); #1;
      axi.rready = 1'b0;
      if (i < int'(len))
        check("r_next_xfer", xfer_valid_o, !oor(beat_addr(addr, size, len, burst, i + 1)));
    end
    compare_core("rd");
  endtask

  function automatic logic [127:0] all_outputs();
    return {axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp, axi.arready, axi.rvalid,
            axi.rid, axi.rdata, axi.rresp, axi.rlast, xfer_valid_o, xfer_rdwr_o,
            bus_addr_o, bus_wr_data_o, bus_wr_mask_o};
  endfunction

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    rst_i = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.arvalid = 1'b0; axi.rready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Single write with fixed data and partial mask.
    write_txn(4'h3, 32'h10, 8'd0, 3'd2, 2'b01, -1, 32'hA5A5_1234, 4'b0011, 1'b1);
    // INCR and WRAP reads.
    read_txn(4'h7, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
    read_txn(4'h8, 32'h38, 8'd3, 3'd2, 2'b10, 1'b1);

    // Three back-to-back ties: write, read, write.
    @(negedge clk);
    axi.awid = 4'h1; axi.awaddr = 32'h400; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01;
    axi.arid = 4'h2; axi.araddr = 32'h500; axi.arlen = 8'd1; axi.arsize = 3'd2; axi.arburst = 2'b01;
    axi.awvalid = 1'b1; axi.arvalid = 1'b1;
    #1 check("arb_round1", {axi.awready, axi.arready}, 2'b10);
    @(posedge clk); #1 axi.awvalid = 1'b0;
    write_txn(4'h1, 32'h400, 8'd0, 3'd2, 2'b01, -1, 32'h0, 4'h0, 1'b0);
    axi.awid = 4'h4; axi.awaddr = 32'h404; axi.awvalid = 1'b1;
    #1 check("arb_round2", {axi.awready, axi.arready}, 2'b01);
    @(posedge clk); #1 axi.arvalid = 1'b0;
    read_txn(4'h2, 32'h500, 8'd1, 3'd2, 2'b01, 1'b0);
    axi.arid = 4'h5; axi.araddr = 32'h600; axi.arlen = 8'd0; axi.arvalid = 1'b1;
    #1 check("arb_round3", {axi.awready, axi.arready}, 2'b10);
    @(posedge clk); #1 axi.awvalid = 1'b0;
    write_txn(4'h4, 32'h404, 8'd0, 3'd2, 2'b01, -1, 32'h0, 4'h0, 1'b0);
    read_txn(4'h5, 32'h600, 8'd0, 3'd2, 2'b01, 1'b1);

    // Out-of-range write and read, wlast mismatch, FIXED, reserved, straddle.
    write_txn(4'h9, 32'(USR), 8'd1, 3'd2, 2'b01, -1, 32'h0, 4'h0, 1'b1);
    read_txn(4'hA, 32'(USR), 8'd0, 3'd2, 2'b01, 1'b1);
    write_txn(4'hB, 32'h80, 8'd1, 3'd2, 2'b01, 0, 32'h0, 4'h0, 1'b1);
    write_txn(4'hC, 32'h60, 8'd2, 3'd2, 2'b00, -1, 32'h0, 4'h0, 1'b1);
    read_txn(4'hD, 32'h200, 8'd1, 3'd2, 2'b11, 1'b1);
    read_txn(4'hE, 32'(USR - 8), 8'd3, 3'd2, 2'b01, 1'b1);

    // Reset while a read waits on the core.
    core_hold = 1'b1;
    ar_hs(4'h5, 32'h200, 8'd0, 3'd2, 2'b01);
    check("rst_pre_xfer", xfer_valid_o, 1'b1);
    @(negedge clk);
    rst_i = 1'b1;
    #1 check("rst_mid_burst", all_outputs(), '0);
    @(negedge clk);
    rst_i     = 1'b0;
    core_hold = 1'b0;
    core_wait = 0;
    obs_q.delete();
    read_txn(4'h6, 32'h204, 8'd0, 3'd2, 2'b01, 1'b1);

    // Randomized bursts, some near the top of the mapped window.
    for (int k = 0; k < 24; k++) begin
      rb = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 2));
      if (rb == 2'b10) rl = 8'((2 << $urandom_range(0, 2)) - 1);
      else             rl = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ra = 32'(USR - 32 + $urandom_range(0, 31));
      else                           ra = 32'($urandom_range(0, 32'hFFFF));
      ra = ra & ~((32'h1 << rs) - 32'h1);
      if ($urandom_range(0, 1) == 1)
        write_txn(4'($urandom), ra, rl, rs, rb, -1, 32'h0, 4'h0, 1'b1);
      else
        read_txn(4'($urandom), ra, rl, rs, rb, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
